// File: rtl/mem_port_arbiter.sv
// Arbitrates a single fixed-latency memory between the fetch and data ports.
// Define ARB_RR_EN for a round-robin tie-break; the default build uses fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       owner, owner_nxt;   // 1 = data port owns the access
  logic       we, we_nxt;
  logic       any_req, gnt_d;

  assign any_req = i_req | d_req;

`ifdef ARB_RR_EN
  logic last_gnt;                 // 1 = data won the last grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       last_gnt <= 1'b1;
    else if (state == IDLE && any_req) last_gnt <= gnt_d;
  assign gnt_d = d_req & (~i_req | ~last_gnt);
`else
  assign gnt_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    we_nxt    = we;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        // Grant strobe is gated by reset so every output is quiet while held in reset.
        if (any_req && rst_n) begin
          mem_en    = 1'b1;
          mem_we    = gnt_d & d_we;
          mem_addr  = gnt_d ? d_addr : i_addr;
          mem_wdata = gnt_d ? d_wdata : '0;
          owner_nxt = gnt_d;
          we_nxt    = gnt_d & d_we;
          cnt_nxt   = 4'(MEM_LATENCY - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      we    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      we    <= we_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (state == BUSY && cnt == 4'd0 && !we) begin
      if (owner) d_rdata <= mem_rdata;
      else       i_rdata <= mem_rdata;
    end
  end

  assign i_rvalid = (state == RESP) & ~owner;
  assign d_rvalid = (state == RESP) &  owner;
  assign i_stall  = rst_n & i_req & ~i_rvalid;
  assign d_stall  = rst_n & d_req & ~d_rvalid;
endmodule
